frame_buffer_writer: RTL and testbench

//  Write side of the 240x320 RGB565 frame buffer. Accepts the camera pixel stream,

---
 rtl/fb_pkg.sv | 26 ++
 rtl/frame_buffer_writer.sv | 177 +++++++++++++++++
 tb/tb_frame_buffer_writer.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared definitions for the frame-buffer write path.
// Contents:
//   FB_WIDTH / FB_HEIGHT   buffer geometry in pixels (240 x 320)
//   FB_DEPTH               number of pixel words in the buffer (76800)
//   FB_ADDR_W              BRAM address width (17 bits covers 0..76799)
//   PIX_W                  pixel width, RGB565
//   COL_W / ROW_W          counter widths; COL_W must hold FB_WIDTH itself
//                          because the column counter saturates there
//   fb_wr_state_t          write-side FSM states
package fb_pkg;

  localparam int unsigned FB_WIDTH  = 240;
  localparam int unsigned FB_HEIGHT = 320;
  localparam int unsigned FB_DEPTH  = FB_WIDTH * FB_HEIGHT;
  localparam int unsigned FB_ADDR_W = 17;
  localparam int unsigned PIX_W     = 16;
  localparam int unsigned COL_W     = 8;
  localparam int unsigned ROW_W     = 9;

  typedef enum logic [1:0] {
    WR_IDLE    = 2'd0,
    WR_CAPTURE = 2'd1,
    WR_DONE    = 2'd2
  } fb_wr_state_t;

endpackage

// File: rtl/frame_buffer_writer.sv
// Write side of the 240x320 RGB565 frame buffer.
// Takes the reconstructed camera pixel stream, tracks column and row, crops
// anything outside the buffer and drives BRAM port A. The buffer is laid out
// row-major: addr = col + FB_WIDTH*row.
// Ports:
//   clk_in          system clock
//   rst_in          synchronous, active-high reset
//   capture_en_in   sampled on frame_start_in; 0 leaves the buffer untouched
//   frame_start_in  1-cycle pulse on the first cycle of a camera frame
//   line_end_in     1-cycle pulse after the last pixel of a line
//   pixel_valid_in  pixel_in carries a pixel this cycle
//   pixel_in        pixel data
//   pixel_addr_out  BRAM write address (registered)
//   pixel_out       BRAM write data (registered)
//   we_out          BRAM write enable (registered, 1 cycle after the pixel)
//   frame_done_out  1-cycle pulse when the last buffer row has been written
//   busy_out        high while capturing a frame
module frame_buffer_writer
  import fb_pkg::*;
(
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 capture_en_in,
  input  logic                 frame_start_in,
  input  logic                 line_end_in,
  input  logic                 pixel_valid_in,
  input  logic [PIX_W-1:0]     pixel_in,
  output logic [FB_ADDR_W-1:0] pixel_addr_out,
  output logic [PIX_W-1:0]     pixel_out,
  output logic                 we_out,
  output logic                 frame_done_out,
  output logic                 busy_out
);

  localparam logic [COL_W-1:0]     COL_ZERO    = COL_W'(0);
  localparam logic [COL_W-1:0]     COL_ONE     = COL_W'(1);
  localparam logic [COL_W-1:0]     COL_LIMIT   = COL_W'(FB_WIDTH);
  localparam logic [ROW_W-1:0]     ROW_ZERO    = ROW_W'(0);
  localparam logic [ROW_W-1:0]     ROW_ONE     = ROW_W'(1);
  localparam logic [ROW_W-1:0]     ROW_LAST    = ROW_W'(FB_HEIGHT - 1);
  localparam logic [FB_ADDR_W-1:0] ADDR_ZERO   = FB_ADDR_W'(0);
  localparam logic [FB_ADDR_W-1:0] LINE_STRIDE = FB_ADDR_W'(FB_WIDTH);
  localparam logic [PIX_W-1:0]     PIX_ZERO    = PIX_W'(0);

  fb_wr_state_t         state_r, state_next_s;
  logic [COL_W-1:0]     col_r, col_next_s;
  logic [ROW_W-1:0]     row_r, row_next_s;
  // row_base_r = FB_WIDTH*row_r, kept by accumulation so no multiplier is needed
  logic [FB_ADDR_W-1:0] row_base_r, row_base_next_s;

  logic                 wr_en_s;
  logic [FB_ADDR_W-1:0] wr_addr_s;
  logic                 done_s;

  logic [FB_ADDR_W-1:0] addr_r;
  logic [PIX_W-1:0]     pix_r;
  logic                 we_r;
  logic                 done_r;
  logic                 busy_r;

  // Next-state, counter update and write-request decode
  always_comb begin
    state_next_s    = state_r;
    col_next_s      = col_r;
    row_next_s      = row_r;
    row_base_next_s = row_base_r;
    wr_en_s         = 1'b0;
    wr_addr_s       = row_base_r + {{(FB_ADDR_W-COL_W){1'b0}}, col_r};
    done_s          = 1'b0;

    if (frame_start_in) begin
      // frame_start overrides everything, including a coincident line_end,
      // and silently aborts a frame in progress (no done pulse).
      col_next_s      = COL_ZERO;
      row_next_s      = ROW_ZERO;
      row_base_next_s = ADDR_ZERO;
      if (capture_en_in) begin
        state_next_s = WR_CAPTURE;
        if (pixel_valid_in) begin
          // A coincident pixel is pixel 0 of the new frame.
          wr_en_s    = 1'b1;
          wr_addr_s  = ADDR_ZERO;
          col_next_s = COL_ONE;
        end else begin
          wr_en_s = 1'b0;
        end
      end else begin
        state_next_s = WR_IDLE;
      end
    end else begin
      case (state_r)
        WR_IDLE: begin
          state_next_s = WR_IDLE;
        end
        WR_CAPTURE: begin
          // col saturates at FB_WIDTH so cropped pixels never wrap into the next row.
          if (pixel_valid_in && (col_r < COL_LIMIT)) begin
            wr_en_s    = 1'b1;
            col_next_s = col_r + COL_ONE;
          end else begin
            wr_en_s = 1'b0;
          end
          // line_end is evaluated after the pixel: a same-cycle pixel lands on the old row.
          if (line_end_in) begin
            if (row_r == ROW_LAST) begin
              state_next_s    = WR_DONE;
              done_s          = 1'b1;
              col_next_s      = COL_ZERO;
              row_next_s      = ROW_ZERO;
              row_base_next_s = ADDR_ZERO;
            end else begin
              col_next_s      = COL_ZERO;
              row_next_s      = row_r + ROW_ONE;
              row_base_next_s = row_base_r + LINE_STRIDE;
            end
          end else begin
            row_next_s = row_r;
          end
        end
        WR_DONE: begin
          state_next_s = WR_IDLE;
        end
        default: begin
          state_next_s    = WR_IDLE;
          col_next_s      = COL_ZERO;
          row_next_s      = ROW_ZERO;
          row_base_next_s = ADDR_ZERO;
        end
      endcase
    end
  end

  // FSM state and position counters
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_r    <= WR_IDLE;
      col_r      <= COL_ZERO;
      row_r      <= ROW_ZERO;
      row_base_r <= ADDR_ZERO;
    end else begin
      state_r    <= state_next_s;
      col_r      <= col_next_s;
      row_r      <= row_next_s;
      row_base_r <= row_base_next_s;
    end
  end

  // Output register stage: one cycle from accepted pixel to BRAM write
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      addr_r <= ADDR_ZERO;
      pix_r  <= PIX_ZERO;
      we_r   <= 1'b0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
    end else begin
      we_r   <= wr_en_s;
      done_r <= done_s;
      busy_r <= (state_next_s == WR_CAPTURE);
      // Address/data only move on a write to avoid needless BRAM-port toggling.
      if (wr_en_s) begin
        addr_r <= wr_addr_s;
        pix_r  <= pixel_in;
      end else begin
        addr_r <= addr_r;
        pix_r  <= pix_r;
      end
    end
  end

  assign pixel_addr_out = addr_r;
  assign pixel_out      = pix_r;
  assign we_out         = we_r;
  assign frame_done_out = done_r;
  assign busy_out       = busy_r;

endmodule

// File: tb/tb_frame_buffer_writer.sv
module tb_frame_buffer_writer;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        capture_en_in = 1'b0;
  logic        frame_start_in = 1'b0;
  logic        line_end_in = 1'b0;
  logic        pixel_valid_in = 1'b0;
  logic [15:0] pixel_in = 16'd0;
  logic [16:0] pixel_addr_out;
  logic [15:0] pixel_out;
  logic        we_out;
  logic        frame_done_out;
  logic        busy_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] exp_addr_q[$];
  logic [15:0] exp_data_q[$];
  logic [16:0] wr_log[$];
  int          done_cnt = 0;
  logic        done_with_we = 1'b0;
  logic        busy_seen = 1'b0;

  frame_buffer_writer dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .capture_en_in  (capture_en_in),
    .frame_start_in (frame_start_in),
    .line_end_in    (line_end_in),
    .pixel_valid_in (pixel_valid_in),
    .pixel_in       (pixel_in),
    .pixel_addr_out (pixel_addr_out),
    .pixel_out      (pixel_out),
    .we_out         (we_out),
    .frame_done_out (frame_done_out),
    .busy_out       (busy_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] pix_of(input int c, input int r);
    return 16'((c * 31 + r * 977) ^ 16'h5A3C);
  endfunction

  // Write monitor: sampled on the falling edge, away from the active edge
  always @(negedge clk_in) begin
    if (we_out) begin
      wr_log.push_back(pixel_addr_out);
      if (exp_addr_q.size() == 0) begin
        check_eq("unexpected_we", {15'd0, pixel_addr_out}, 32'hFFFF_FFFF);
      end else begin
        check_eq("wr_addr", {15'd0, pixel_addr_out}, {15'd0, exp_addr_q.pop_front()});
        check_eq("wr_data", {16'd0, pixel_out}, {16'd0, exp_data_q.pop_front()});
      end
    end
    if (frame_done_out) begin
      done_cnt++;
      done_with_we = we_out;
    end
    if (busy_out) busy_seen = 1'b1;
  end

  task automatic step(input logic fs, input logic le, input logic pv, input logic [15:0] pix);
    frame_start_in = fs;
    line_end_in    = le;
    pixel_valid_in = pv;
    pixel_in       = pix;
    @(posedge clk_in);
    #1;
    frame_start_in = 1'b0;
    line_end_in    = 1'b0;
    pixel_valid_in = 1'b0;
  endtask

  task automatic clear_log();
    wr_log.delete();
    done_cnt     = 0;
    done_with_we = 1'b0;
    busy_seen    = 1'b0;
  endtask

  task automatic expect_wr(input int addr, input logic [15:0] data);
    exp_addr_q.push_back(17'(addr));
    exp_data_q.push_back(data);
  endtask

  // n_pix pixels on buffer row 'row'; expected writes only for col < 240
  task automatic send_line(input int n_pix, input int row, input bit exp_wr, input bit merge_le);
    logic [15:0] p;
    for (int c = 0; c < n_pix; c++) begin
      p = pix_of(c, row);
      if (exp_wr && c < 240) expect_wr(c + 240 * row, p);
      step(1'b0, merge_le && (c == n_pix - 1), 1'b1, p);
    end
    if (!merge_le || n_pix == 0) step(1'b0, 1'b1, 1'b0, 16'd0);
  endtask

  initial begin
    // Reset
    step(1'b0, 1'b0, 1'b0, 16'd0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("rst_we", {31'd0, we_out}, 32'd0);
    check_eq("rst_addr", {15'd0, pixel_addr_out}, 32'd0);
    check_eq("rst_pix", {16'd0, pixel_out}, 32'd0);
    check_eq("rst_done", {31'd0, frame_done_out}, 32'd0);
    check_eq("rst_busy", {31'd0, busy_out}, 32'd0);
    rst_in = 1'b0;
    step(1'b0, 1'b0, 1'b0, 16'd0);

    // 1: full 240x320 frame, last pixel of each line merged with line_end
    clear_log();
    capture_en_in = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'd0);
    check_eq("t1_busy", {31'd0, busy_out}, 32'd1);
    for (int r = 0; r < 320; r++) send_line(240, r, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("t1_writes", wr_log.size(), 32'd76800);
    check_eq("t1_first_addr", {15'd0, wr_log[0]}, 32'd0);
    check_eq("t1_last_addr", {15'd0, wr_log[76799]}, 32'd76799);
    check_eq("t1_done_cnt", done_cnt, 32'd1);
    check_eq("t1_done_with_we", {31'd0, done_with_we}, 32'd1);
    check_eq("t1_busy_after", {31'd0, busy_out}, 32'd0);

    // 2: over-wide lines and an over-tall frame are cropped
    clear_log();
    step(1'b1, 1'b0, 1'b0, 16'd0);
    send_line(320, 0, 1'b1, 1'b0);
    send_line(320, 1, 1'b1, 1'b0);
    for (int r = 2; r < 320; r++) send_line(0, r, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("t2_done_cnt", done_cnt, 32'd1);
    check_eq("t2_busy_after", {31'd0, busy_out}, 32'd0);
    for (int r = 320; r < 400; r++) send_line(4, r, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("t2_writes", wr_log.size(), 32'd480);
    check_eq("t2_line0_last", {15'd0, wr_log[239]}, 32'd239);
    check_eq("t2_line1_first", {15'd0, wr_log[240]}, 32'd240);
    check_eq("t2_done_cnt_end", done_cnt, 32'd1);

    // 3: capture disabled -> frame ignored
    clear_log();
    capture_en_in = 1'b0;
    step(1'b1, 1'b0, 1'b0, 16'd0);
    for (int r = 0; r < 5; r++) send_line(10, r, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("t3_writes", wr_log.size(), 32'd0);
    check_eq("t3_busy_seen", {31'd0, busy_seen}, 32'd0);
    check_eq("t3_done_cnt", done_cnt, 32'd0);

    // 4: frame_start (with a pixel) at row 100 col 50 restarts at addr 0
    clear_log();
    capture_en_in = 1'b1;
    step(1'b1, 1'b0, 1'b0, 16'd0);
    for (int r = 0; r < 100; r++) send_line(0, r, 1'b1, 1'b0);
    for (int c = 0; c < 50; c++) begin
      expect_wr(24000 + c, pix_of(c, 100));
      step(1'b0, 1'b0, 1'b1, pix_of(c, 100));
    end
    expect_wr(0, 16'hBEEF);
    step(1'b1, 1'b0, 1'b1, 16'hBEEF);
    expect_wr(1, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 16'h1234);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("t4_pre_abort", {15'd0, wr_log[49]}, 32'd24049);
    check_eq("t4_restart_addr", {15'd0, wr_log[50]}, 32'd0);
    check_eq("t4_next_addr", {15'd0, wr_log[51]}, 32'd1);
    check_eq("t4_done_cnt", done_cnt, 32'd0);
    check_eq("t4_busy", {31'd0, busy_out}, 32'd1);

    // 5: frame_start & line_end together; pixel & line_end together at col 10 row 2
    clear_log();
    step(1'b1, 1'b1, 1'b0, 16'd0);
    send_line(5, 0, 1'b1, 1'b0);
    send_line(0, 1, 1'b1, 1'b0);
    send_line(11, 2, 1'b1, 1'b1);
    send_line(1, 3, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("t5_writes", wr_log.size(), 32'd17);
    check_eq("t5_row0_kept", {15'd0, wr_log[0]}, 32'd0);
    check_eq("t5_merged_addr", {15'd0, wr_log[15]}, 32'd490);
    check_eq("t5_next_line", {15'd0, wr_log[16]}, 32'd720);

    // 6: reset mid-frame, pixels ignored until the next frame_start
    clear_log();
    for (int c = 0; c < 3; c++) begin
      expect_wr(960 + c, pix_of(c, 4));
      step(1'b0, 1'b0, 1'b1, pix_of(c, 4));
    end
    rst_in = 1'b1;
    step(1'b0, 1'b0, 1'b1, 16'hAAAA);
    rst_in = 1'b0;
    check_eq("t6_we_after_rst", {31'd0, we_out}, 32'd0);
    check_eq("t6_busy_after_rst", {31'd0, busy_out}, 32'd0);
    check_eq("t6_addr_after_rst", {15'd0, pixel_addr_out}, 32'd0);
    for (int r = 0; r < 2; r++) send_line(20, r, 1'b0, 1'b0);
    check_eq("t6_idle_writes", wr_log.size(), 32'd3);
    expect_wr(0, 16'h0F0F);
    step(1'b1, 1'b0, 1'b1, 16'h0F0F);
    step(1'b0, 1'b0, 1'b0, 16'd0);
    check_eq("t6_writes", wr_log.size(), 32'd4);
    check_eq("t6_restart_addr", {15'd0, wr_log[3]}, 32'd0);
    check_eq("t6_done_cnt", done_cnt, 32'd0);

    check_eq("exp_queue_left", exp_addr_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
